// File: rtl/pad_mon_pkg.sv
// Shared definitions for the pad supply monitor.
//   - Default synchronizer depth and debounce length.
//   - FSM state encoding (also exported on the STATE port).
//   - Helper that maps a state to the debounced pad level.
package pad_mon_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_LOW       = 3'd1,
    ST_QUAL_HIGH = 3'd2,
    ST_HIGH      = 3'd3,
    ST_QUAL_LOW  = 3'd4
  } mon_state_e;

  // While qualifying a fall the previously accepted level (high) is still
  // reported, so PWR_GOOD is high in HIGH and QUAL_LOW.
  function automatic logic pwr_level(input mon_state_e s);
    return (s == ST_HIGH) || (s == ST_QUAL_LOW);
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   i_clk    - destination clock
//   i_rst_n  - asynchronous active-low reset, clears every stage
//   i_async  - input asynchronous to i_clk
//   o_sync   - synchronized output (last stage)
module pad_sync
  import pad_mon_pkg::*;
#(
  parameter int DEPTH = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_sync[DEPTH-1];

endmodule

// File: rtl/pad_supply_monitor.sv
// Debounced monitor for a supply/sense pad.
// The raw pad level is synchronized, then a five-state FSM only accepts a
// level change after it has stayed stable for DEBOUNCE_CYCLES qualifying
// cycles. Aborted qualifications are counted as glitches.
// Ports:
//   HCLK        - clock, all state on rising edge
//   HRESETn     - asynchronous active-low reset
//   PAD_I       - raw pad receive path, asynchronous
//   EN          - monitor enable; low forces DISABLED
//   CLR_GLITCH  - synchronous clear of GLITCH_CNT (wins over an increment)
//   PWR_GOOD    - registered debounced level
//   RISE_EVT    - one-cycle pulse when PWR_GOOD rises
//   FALL_EVT    - one-cycle pulse when PWR_GOOD falls
//   GLITCH_CNT  - saturating count of rejected qualifications
//   STATE       - current FSM state encoding
module pad_supply_monitor
  import pad_mon_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       PAD_I,
  input  logic       EN,
  input  logic       CLR_GLITCH,
  output logic       PWR_GOOD,
  output logic       RISE_EVT,
  output logic       FALL_EVT,
  output logic [7:0] GLITCH_CNT,
  output logic [2:0] STATE
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       w_sync;
  mon_state_e r_state;
  mon_state_e w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_glitch;
  logic       w_rise_nxt;
  logic       w_fall_nxt;
  logic [7:0] r_glitch_cnt;
  logic       r_pwr_good;
  logic       r_rise;
  logic       r_fall;

  pad_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_pad_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_async (PAD_I),
    .o_sync  (w_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_glitch    = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    // Disable overrides everything, including a pending glitch or event.
    if (!EN) begin
      w_state_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED: w_state_nxt = ST_LOW;
        ST_LOW: begin
          if (w_sync) begin
            w_state_nxt = ST_QUAL_HIGH;
            w_cnt_nxt   = 8'd0;
          end
        end
        ST_QUAL_HIGH: begin
          if (!w_sync) begin
            w_state_nxt = ST_LOW;
            w_glitch    = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_HIGH;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (!w_sync) begin
            w_state_nxt = ST_QUAL_LOW;
            w_cnt_nxt   = 8'd0;
          end
        end
        ST_QUAL_LOW: begin
          if (w_sync) begin
            w_state_nxt = ST_HIGH;
            w_glitch    = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_LOW;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: w_state_nxt = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_DISABLED;
      r_cnt      <= 8'd0;
      r_pwr_good <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      // Outputs are registered from the next state so they line up with STATE.
      r_pwr_good <= pwr_level(w_state_nxt);
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_glitch_cnt <= 8'd0;
    end else if (CLR_GLITCH) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign PWR_GOOD   = r_pwr_good;
  assign RISE_EVT   = r_rise;
  assign FALL_EVT   = r_fall;
  assign GLITCH_CNT = r_glitch_cnt;
  assign STATE      = r_state;

endmodule

// File: tb/tb_pad_supply_monitor.sv
// Directed bench for pad_supply_monitor (default parameters).
// Stimulus pushes the expected RISE/FALL events (kind + edge index) into a
// queue; a monitor pops and compares whenever the DUT pulses an event.
// Level outputs are checked directly at chosen points.
// Edge numbering: edge_n counts rising edges; a pad change applied at a
// negedge takes effect at "edge 0" = edge_n+1, and the accepting edge is
// edge 0 + SYNC_STAGES + DEBOUNCE_CYCLES = edge 0 + 18.
module tb_pad_supply_monitor;

  localparam int LAT = 18;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       PAD_I = 1'b0;
  logic       EN = 1'b0;
  logic       CLR_GLITCH = 1'b0;
  logic       PWR_GOOD;
  logic       RISE_EVT;
  logic       FALL_EVT;
  logic [7:0] GLITCH_CNT;
  logic [2:0] STATE;

  pad_supply_monitor dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .PAD_I      (PAD_I),
    .EN         (EN),
    .CLR_GLITCH (CLR_GLITCH),
    .PWR_GOOD   (PWR_GOOD),
    .RISE_EVT   (RISE_EVT),
    .FALL_EVT   (FALL_EVT),
    .GLITCH_CNT (GLITCH_CNT),
    .STATE      (STATE)
  );

  always #5 HCLK = ~HCLK;

  int edge_n = 0;
  always @(posedge HCLK) edge_n <= edge_n + 1;

  typedef struct {
    bit is_rise;
    int at_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge HCLK);
  endtask

  task automatic expect_evt(input bit is_rise, input int at_edge);
    exp_t e;
    e.is_rise = is_rise;
    e.at_edge = at_edge;
    exp_q.push_back(e);
  endtask

  // Event monitor
  always @(negedge HCLK) begin
    exp_t e;
    if (RISE_EVT === 1'b1 || FALL_EVT === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_evt: rise=%0b fall=%0b at edge %0d, queue empty",
                 RISE_EVT, FALL_EVT, edge_n);
      end else begin
        e = exp_q.pop_front();
        chk("evt_rise", int'(RISE_EVT), int'(e.is_rise));
        chk("evt_fall", int'(FALL_EVT), int'(!e.is_rise));
        chk("evt_edge", edge_n, e.at_edge);
      end
    end else if (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_evt: rise=%0b expected at edge %0d, absent through edge %0d",
               e.is_rise, e.at_edge, edge_n);
    end
  end

  initial begin
    int e0;
    int e1;
    int p;
    int a;

    // Reset state
    tick(3);
    chk("rst_pwr", int'(PWR_GOOD), 0);
    chk("rst_rise", int'(RISE_EVT), 0);
    chk("rst_fall", int'(FALL_EVT), 0);
    chk("rst_glitch", int'(GLITCH_CNT), 0);
    chk("rst_state", int'(STATE), 0);
    HRESETn = 1'b1;
    EN      = 1'b1;
    tick(3);
    chk("en_state_low", int'(STATE), 1);

    // Clean rise
    PAD_I = 1'b1;
    e0 = edge_n + 1;
    expect_evt(1'b1, e0 + LAT);
    wait_edge(e0 + LAT - 1);
    chk("rise_pwr_before", int'(PWR_GOOD), 0);
    tick(1);
    chk("rise_pwr_after", int'(PWR_GOOD), 1);
    chk("rise_state", int'(STATE), 3);
    tick(2);
    chk("rise_glitch", int'(GLITCH_CNT), 0);

    // 5-cycle low glitch while HIGH
    PAD_I = 1'b0;
    p = edge_n + 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("glitch5_pwr_hold", int'(PWR_GOOD), 1);
    end
    PAD_I = 1'b1;
    chk("glitch5_state_qual", int'(STATE), 4);
    wait_edge(p + 7);
    chk("glitch5_state_back", int'(STATE), 3);
    chk("glitch5_cnt", int'(GLITCH_CNT), 1);
    chk("glitch5_pwr", int'(PWR_GOOD), 1);

    // Clean fall to LOW
    PAD_I = 1'b0;
    e0 = edge_n + 1;
    expect_evt(1'b0, e0 + LAT);
    wait_edge(e0 + LAT - 1);
    chk("fall_pwr_before", int'(PWR_GOOD), 1);
    tick(1);
    chk("fall_pwr_after", int'(PWR_GOOD), 0);
    wait_edge(e0 + LAT + 2);
    chk("fall_state", int'(STATE), 1);
    chk("fall_glitch", int'(GLITCH_CNT), 1);

    // Boundary: the qualifying window starts at the LOW->QUAL_HIGH edge and
    // then needs sync high for DEBOUNCE_CYCLES counted cycles. A 16-cycle pad
    // pulse gives 15 counted cycles (rejected); 17 gives 16 (accepted).
    PAD_I = 1'b1;
    e0 = edge_n + 1;
    tick(16);
    PAD_I = 1'b0;
    wait_edge(e0 + LAT + 2);
    chk("bnd15_glitch", int'(GLITCH_CNT), 2);
    chk("bnd15_state", int'(STATE), 1);
    chk("bnd15_pwr", int'(PWR_GOOD), 0);

    PAD_I = 1'b1;
    e0 = edge_n + 1;
    expect_evt(1'b1, e0 + LAT);
    tick(17);
    PAD_I = 1'b0;
    e1 = e0 + 17;
    expect_evt(1'b0, e1 + LAT);
    wait_edge(e0 + LAT);
    chk("bnd16_pwr", int'(PWR_GOOD), 1);
    chk("bnd16_state", int'(STATE), 3);
    wait_edge(e1 + LAT + 1);
    chk("bnd16_state_end", int'(STATE), 1);
    chk("bnd16_glitch", int'(GLITCH_CNT), 2);

    // Disable mid-operation
    PAD_I = 1'b1;
    e0 = edge_n + 1;
    expect_evt(1'b1, e0 + LAT);
    wait_edge(e0 + LAT + 1);
    EN = 1'b0;
    tick(1);
    chk("dis_state", int'(STATE), 0);
    chk("dis_pwr", int'(PWR_GOOD), 0);
    tick(2);
    chk("dis_state_hold", int'(STATE), 0);
    EN = 1'b1;
    a = edge_n + 1;
    expect_evt(1'b1, a + 17);
    wait_edge(a + 16);
    chk("reen_pwr_before", int'(PWR_GOOD), 0);
    tick(1);
    chk("reen_pwr_after", int'(PWR_GOOD), 1);

    // Back to LOW, then reset during QUAL_HIGH with cnt=10
    PAD_I = 1'b0;
    e0 = edge_n + 1;
    expect_evt(1'b0, e0 + LAT);
    wait_edge(e0 + LAT + 2);
    PAD_I = 1'b1;
    e0 = edge_n + 1;
    wait_edge(e0 + 12);
    chk("mid_state_qual", int'(STATE), 2);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_state", int'(STATE), 0);
    chk("arst_pwr", int'(PWR_GOOD), 0);
    chk("arst_glitch", int'(GLITCH_CNT), 0);
    chk("arst_rise", int'(RISE_EVT), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    e0 = edge_n + 1;
    expect_evt(1'b1, e0 + LAT);
    wait_edge(e0 + LAT - 1);
    chk("rst_relat_before", int'(PWR_GOOD), 0);
    tick(1);
    chk("rst_relat_after", int'(PWR_GOOD), 1);
    chk("rst_relat_glitch", int'(GLITCH_CNT), 0);

    // Saturation: 300 short low glitches while HIGH
    tick(2);
    for (int i = 0; i < 300; i++) begin
      PAD_I = 1'b0;
      tick(1);
      PAD_I = 1'b1;
      tick(3);
      if (i == 0)   chk("sat_cnt_1", int'(GLITCH_CNT), 1);
      if (i == 253) chk("sat_cnt_254", int'(GLITCH_CNT), 254);
      if (i == 254) chk("sat_cnt_255", int'(GLITCH_CNT), 255);
    end
    chk("sat_cnt_300", int'(GLITCH_CNT), 255);
    chk("sat_state", int'(STATE), 3);

    // CLR_GLITCH coincident with a glitch (glitch lands on edge p+3)
    PAD_I = 1'b0;
    tick(1);
    PAD_I = 1'b1;
    tick(2);
    CLR_GLITCH = 1'b1;
    tick(1);
    CLR_GLITCH = 1'b0;
    chk("clr_cnt", int'(GLITCH_CNT), 0);
    chk("clr_state", int'(STATE), 3);

    tick(5);
    chk("evt_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
